// File: rtl/alu_result_bcd_if.sv
`default_nettype none
// ============================================================================
// Module : alu_result_bcd_if
// Brief  : Request/result bundle between the ALU side and the BCD converter.
// Rev    : 1.0
// ============================================================================
interface alu_result_bcd_if;
  logic       start;
  logic [7:0] value;
  logic       signed_mode;
  logic       busy;
  logic       done;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       negative;
  logic       blank_hundreds;
  logic       blank_tens;

  modport master (
    output start, value, signed_mode,
    input  busy, done, hundreds, tens, ones, negative, blank_hundreds, blank_tens
  );

  modport slave (
    input  start, value, signed_mode,
    output busy, done, hundreds, tens, ones, negative, blank_hundreds, blank_tens
  );
endinterface
`default_nettype wire

// File: rtl/alu_result_bcd.sv
`default_nettype none
// ============================================================================
// Module : alu_result_bcd
// Brief  : 8-bit binary (unsigned / two's complement) to 3-digit BCD converter
//          using an 8-iteration shift-add-3 sequence.
// Rev    : 1.0
// ============================================================================
module alu_result_bcd (
  input  logic               clk,
  input  logic               reset,
  alu_result_bcd_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic [3:0]  hundreds_q, hundreds_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic        negative_q, negative_d;
  logic        blank_hundreds_q, blank_hundreds_d;
  logic        blank_tens_q, blank_tens_d;
  logic        done_q, done_d;

  logic        in_negative;
  logic [7:0]  in_magnitude;
  logic [11:0] bcd_adj;

  function automatic logic [3:0] add3(input logic [3:0] nib);
    add3 = (nib >= 4'd5) ? (nib + 4'd3) : nib;
  endfunction

  // 0x80 in signed mode negates to itself, which reads back correctly as 128.
  assign in_negative  = bus.signed_mode & bus.value[7];
  assign in_magnitude = in_negative ? (~bus.value + 8'd1) : bus.value;

  assign bcd_adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};

  always_comb begin
    state_d          = state_q;
    bin_d            = bin_q;
    bcd_d            = bcd_q;
    cnt_d            = cnt_q;
    sign_d           = sign_q;
    hundreds_d       = hundreds_q;
    tens_d           = tens_q;
    ones_d           = ones_q;
    negative_d       = negative_q;
    blank_hundreds_d = blank_hundreds_q;
    blank_tens_d     = blank_tens_q;
    done_d           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          bin_d   = in_magnitude;
          bcd_d   = 12'd0;
          cnt_d   = 3'd0;
          sign_d  = in_negative;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = ST_FINISH;
        end
      end

      ST_FINISH: begin
        // Displayed digits only change here, so the seven-seg never sees scratch values.
        hundreds_d       = bcd_q[11:8];
        tens_d           = bcd_q[7:4];
        ones_d           = bcd_q[3:0];
        negative_d       = sign_q;
        blank_hundreds_d = (bcd_q[11:8] == 4'd0);
        blank_tens_d     = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
        done_d           = 1'b1;
        state_d          = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      bin_q            <= 8'd0;
      bcd_q            <= 12'd0;
      cnt_q            <= 3'd0;
      sign_q           <= 1'b0;
      hundreds_q       <= 4'd0;
      tens_q           <= 4'd0;
      ones_q           <= 4'd0;
      negative_q       <= 1'b0;
      blank_hundreds_q <= 1'b1;
      blank_tens_q     <= 1'b1;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      bin_q            <= bin_d;
      bcd_q            <= bcd_d;
      cnt_q            <= cnt_d;
      sign_q           <= sign_d;
      hundreds_q       <= hundreds_d;
      tens_q           <= tens_d;
      ones_q           <= ones_d;
      negative_q       <= negative_d;
      blank_hundreds_q <= blank_hundreds_d;
      blank_tens_q     <= blank_tens_d;
      done_q           <= done_d;
    end
  end

  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.done           = done_q;
  assign bus.hundreds       = hundreds_q;
  assign bus.tens           = tens_q;
  assign bus.ones           = ones_q;
  assign bus.negative       = negative_q;
  assign bus.blank_hundreds = blank_hundreds_q;
  assign bus.blank_tens     = blank_tens_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_bcd.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_result_bcd
// Brief  : Directed bench for alu_result_bcd with a cycle-level arithmetic model.
// Rev    : 1.0
// ============================================================================
module tb_alu_result_bcd;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  alu_result_bcd_if bus ();

  alu_result_bcd dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model: a countdown of cycles to completion plus decimal arithmetic.
  int m_cnt = 0;
  bit m_done = 1'b0;
  int m_h = 0, m_t = 0, m_o = 0;
  bit m_neg = 1'b0, m_bh = 1'b1, m_bt = 1'b1;
  int p_h = 0, p_t = 0, p_o = 0, mag = 0;
  bit p_neg = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_cnt = 0; m_done = 1'b0;
      m_h = 0; m_t = 0; m_o = 0;
      m_neg = 1'b0; m_bh = 1'b1; m_bt = 1'b1;
    end else begin
      m_done = 1'b0;
      if (m_cnt == 0) begin
        if (bus.start === 1'b1) begin
          p_neg = bus.signed_mode && bus.value[7];
          mag   = p_neg ? (256 - int'(bus.value)) : int'(bus.value);
          p_h   = mag / 100;
          p_t   = (mag / 10) % 10;
          p_o   = mag % 10;
          m_cnt = 9;
        end
      end else begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_h = p_h; m_t = p_t; m_o = p_o; m_neg = p_neg;
          m_bh = (p_h == 0);
          m_bt = (p_h == 0) && (p_t == 0);
          m_done = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_busy",     32'(bus.busy),           32'(m_cnt != 0));
      chk("model_done",     32'(bus.done),           32'(m_done));
      chk("model_hundreds", 32'(bus.hundreds),       32'(m_h));
      chk("model_tens",     32'(bus.tens),           32'(m_t));
      chk("model_ones",     32'(bus.ones),           32'(m_o));
      chk("model_negative", 32'(bus.negative),       32'(m_neg));
      chk("model_blank_h",  32'(bus.blank_hundreds), 32'(m_bh));
      chk("model_blank_t",  32'(bus.blank_tens),     32'(m_bt));
    end
  end

  task automatic expect_result(input string tag, input int h, input int t, input int o,
                               input int neg, input int bh, input int bt);
    chk({tag, "_hundreds"}, 32'(bus.hundreds),       32'(h));
    chk({tag, "_tens"},     32'(bus.tens),           32'(t));
    chk({tag, "_ones"},     32'(bus.ones),           32'(o));
    chk({tag, "_negative"}, 32'(bus.negative),       32'(neg));
    chk({tag, "_blank_h"},  32'(bus.blank_hundreds), 32'(bh));
    chk({tag, "_blank_t"},  32'(bus.blank_tens),     32'(bt));
  endtask

  task automatic pulse_start(input logic [7:0] v, input logic s);
    @(negedge clk);
    bus.start = 1'b1; bus.value = v; bus.signed_mode = s;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Returns negedges counted until done is seen; 0 on timeout.
  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done_within_20", tag);
    end
  endtask

  task automatic convert(input string tag, input logic [7:0] v, input logic s);
    int lat;
    pulse_start(v, s);
    chk({tag, "_busy_after_start"}, 32'(bus.busy), 32'd1);
    wait_done(tag, lat);
    chk({tag, "_latency"}, 32'(lat), 32'd9);
    chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int lat;
    bus.start = 1'b0; bus.value = 8'h00; bus.signed_mode = 1'b0;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    cmp_en = 1'b1;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    expect_result("reset", 0, 0, 0, 0, 1, 1);

    convert("u_ff", 8'hFF, 1'b0);
    expect_result("u_ff", 2, 5, 5, 0, 0, 0);

    convert("s_80", 8'h80, 1'b1);
    expect_result("s_80", 1, 2, 8, 1, 0, 0);

    convert("s_f6", 8'hF6, 1'b1);
    expect_result("s_f6", 0, 1, 0, 1, 1, 0);

    convert("u_07", 8'h07, 1'b0);
    expect_result("u_07", 0, 0, 7, 0, 1, 1);
    convert("u_00", 8'h00, 1'b0);
    expect_result("u_00", 0, 0, 0, 0, 1, 1);

    // Start 0x2A; a second start at E3 must be dropped.
    pulse_start(8'h2A, 1'b0);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.value = 8'h63; bus.signed_mode = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("ignore", lat);
    chk("ignore_latency", 32'(lat), 32'd6);
    expect_result("ignore", 0, 4, 2, 0, 1, 0);

    // Start raised during the done cycle is accepted immediately.
    bus.start = 1'b1; bus.value = 8'h63; bus.signed_mode = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    wait_done("b2b", lat);
    chk("b2b_latency", 32'(lat), 32'd9);
    expect_result("b2b", 0, 9, 9, 0, 1, 0);

    convert("u_c8", 8'hC8, 1'b0);
    expect_result("u_c8", 2, 0, 0, 0, 0, 0);

    // Reset at E4 of a conversion of 0x11.
    pulse_start(8'h11, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_done", 32'(bus.done), 32'd0);
    expect_result("rst_mid", 0, 0, 0, 0, 1, 1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("rst_mid_no_done", 32'(bus.done), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
